// File: rtl/sensor_frame_rx.sv
// Receives six-byte distance frames (SYNC, S1..S4, CHK) from the sensor link.
// Only checksum-verified frames reach the outputs, and a stalled frame is aborted after TIMEOUT idle cycles.
module sensor_frame_rx #(
    parameter logic [7:0]  SYNC    = 8'hA5,
    parameter logic [15:0] TIMEOUT = 16'd1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] sensor1,
    output logic [7:0] sensor2,
    output logic [7:0] sensor3,
    output logic [7:0] sensor4,
    output logic       frame_valid,
    output logic       chk_err,
    output logic       timeout_err
);

    typedef enum logic [2:0] {
        HUNT = 3'd0,
        B1   = 3'd1,
        B2   = 3'd2,
        B3   = 3'd3,
        B4   = 3'd4,
        CK   = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] cnt_inc_s;
    logic [7:0]  sum_q, sum_d;
    logic [7:0]  sh1_q, sh1_d, sh2_q, sh2_d, sh3_q, sh3_d, sh4_q, sh4_d;
    logic [7:0]  sen1_q, sen1_d, sen2_q, sen2_d, sen3_q, sen3_d, sen4_q, sen4_d;
    logic        fv_q, fv_d, ce_q, ce_d, to_q, to_d;

    assign cnt_inc_s = cnt_q + 16'd1;

    // Next-state, shadow capture, checksum and idle-timeout logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        sh1_d   = sh1_q;
        sh2_d   = sh2_q;
        sh3_d   = sh3_q;
        sh4_d   = sh4_q;
        sen1_d  = sen1_q;
        sen2_d  = sen2_q;
        sen3_d  = sen3_q;
        sen4_d  = sen4_q;
        fv_d    = 1'b0;
        ce_d    = 1'b0;
        to_d    = 1'b0;
        if (rx_valid) begin
            // An accepted byte always wins over a timeout that would fire this cycle
            cnt_d = 16'd0;
            case (state_q)
                HUNT: begin
                    if (rx_data == SYNC) begin
                        state_d = B1;
                        sum_d   = 8'd0;
                    end else begin
                        state_d = HUNT;
                    end
                end
                B1: begin
                    sh1_d   = rx_data;
                    sum_d   = sum_q + rx_data;
                    state_d = B2;
                end
                B2: begin
                    sh2_d   = rx_data;
                    sum_d   = sum_q + rx_data;
                    state_d = B3;
                end
                B3: begin
                    sh3_d   = rx_data;
                    sum_d   = sum_q + rx_data;
                    state_d = B4;
                end
                B4: begin
                    sh4_d   = rx_data;
                    sum_d   = sum_q + rx_data;
                    state_d = CK;
                end
                CK: begin
                    state_d = HUNT;
                    sum_d   = 8'd0;
                    if (rx_data == sum_q) begin
                        sen1_d = sh1_q;
                        sen2_d = sh2_q;
                        sen3_d = sh3_q;
                        sen4_d = sh4_q;
                        fv_d   = 1'b1;
                    end else begin
                        ce_d = 1'b1;
                    end
                end
                default: begin
                    state_d = HUNT;
                    sum_d   = 8'd0;
                end
            endcase
        end else if (state_q != HUNT) begin
            if (cnt_inc_s == TIMEOUT) begin
                state_d = HUNT;
                cnt_d   = 16'd0;
                sum_d   = 8'd0;
                to_d    = 1'b1;
            end else begin
                cnt_d = cnt_inc_s;
            end
        end else begin
            cnt_d = 16'd0;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HUNT;
            cnt_q   <= 16'd0;
            sum_q   <= 8'd0;
            sh1_q   <= 8'd0;
            sh2_q   <= 8'd0;
            sh3_q   <= 8'd0;
            sh4_q   <= 8'd0;
            sen1_q  <= 8'd0;
            sen2_q  <= 8'd0;
            sen3_q  <= 8'd0;
            sen4_q  <= 8'd0;
            fv_q    <= 1'b0;
            ce_q    <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            sh1_q   <= sh1_d;
            sh2_q   <= sh2_d;
            sh3_q   <= sh3_d;
            sh4_q   <= sh4_d;
            sen1_q  <= sen1_d;
            sen2_q  <= sen2_d;
            sen3_q  <= sen3_d;
            sen4_q  <= sen4_d;
            fv_q    <= fv_d;
            ce_q    <= ce_d;
            to_q    <= to_d;
        end
    end

    assign sensor1     = sen1_q;
    assign sensor2     = sen2_q;
    assign sensor3     = sen3_q;
    assign sensor4     = sen4_q;
    assign frame_valid = fv_q;
    assign chk_err     = ce_q;
    assign timeout_err = to_q;

endmodule

// File: tb/tb_sensor_frame_rx.sv
// Directed self-checking bench for sensor_frame_rx; inputs change and outputs are sampled on the falling edge.
module tb_sensor_frame_rx;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] sensor1, sensor2, sensor3, sensor4;
    logic       frame_valid, chk_err, timeout_err;

    int checks = 0;
    int errors = 0;
    int fv_cnt = 0;
    int ce_cnt = 0;
    int to_cnt = 0;
    int multi_cnt = 0;
    int base_fv, base_ce, base_to;

    sensor_frame_rx #(.SYNC(8'hA5), .TIMEOUT(16'd1000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .sensor1     (sensor1),
        .sensor2     (sensor2),
        .sensor3     (sensor3),
        .sensor4     (sensor4),
        .frame_valid (frame_valid),
        .chk_err     (chk_err),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse tally, sampled mid-cycle
    always @(negedge clk) begin
        if (frame_valid) fv_cnt++;
        if (chk_err) ce_cnt++;
        if (timeout_err) to_cnt++;
        if ((32'(frame_valid) + 32'(chk_err) + 32'(timeout_err)) > 32'd1) multi_cnt++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx_valid = 1'b0;
            rx_data  = 8'h00;
        end
    endtask

    task automatic send_frame(input logic [7:0] s1, input logic [7:0] s2,
                              input logic [7:0] s3, input logic [7:0] s4, input logic [7:0] ck);
        send_byte(8'hA5);
        send_byte(s1);
        send_byte(s2);
        send_byte(s3);
        send_byte(s4);
        send_byte(ck);
    endtask

    function automatic logic [31:0] sens();
        return {sensor1, sensor2, sensor3, sensor4};
    endfunction

    initial begin
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_val("reset_sensors", sens(), 32'h0000_0000);
        check_val("reset_pulses", {29'd0, frame_valid, chk_err, timeout_err}, 32'd0);
        rst_n = 1'b1;

        // Basic good frame
        send_frame(8'h10, 8'h20, 8'h30, 8'h40, 8'hA0);
        idle(1);
        check_val("basic_fv", 32'(frame_valid), 32'd1);
        check_val("basic_sens", sens(), 32'h1020_3040);
        idle(1);
        check_val("basic_fv_one_cycle", 32'(frame_valid), 32'd0);

        // Wrap-around checksum: wrong then right
        send_frame(8'hFF, 8'hFF, 8'h01, 8'h02, 8'h00);
        idle(1);
        check_val("bad_chk_err", 32'(chk_err), 32'd1);
        check_val("bad_chk_fv", 32'(frame_valid), 32'd0);
        check_val("bad_chk_hold", sens(), 32'h1020_3040);
        send_frame(8'hFF, 8'hFF, 8'h01, 8'h02, 8'h01);
        idle(1);
        check_val("wrap_fv", 32'(frame_valid), 32'd1);
        check_val("wrap_sens", sens(), 32'hFFFF_0102);

        // Leading junk discarded, inner SYNC treated as data
        send_byte(8'h00);
        send_byte(8'h37);
        send_frame(8'h01, 8'hA5, 8'h03, 8'h04, 8'hAD);
        idle(1);
        check_val("inner_sync_fv", 32'(frame_valid), 32'd1);
        check_val("inner_sync_sens", sens(), 32'h01A5_0304);

        // Timeout after exactly TIMEOUT idle cycles
        idle(2);
        base_to = to_cnt;
        send_byte(8'hA5);
        send_byte(8'h05);
        idle(999);
        check_val("to_not_early", 32'(timeout_err), 32'd0);
        idle(1);
        idle(1);
        check_val("to_pulse", 32'(timeout_err), 32'd1);
        check_val("to_hold", sens(), 32'h01A5_0304);
        idle(2);
        check_val("to_once", 32'(to_cnt - base_to), 32'd1);
        send_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h0A);
        idle(1);
        check_val("after_to_fv", 32'(frame_valid), 32'd1);
        check_val("after_to_sens", sens(), 32'h0102_0304);

        // Byte arriving after TIMEOUT-1 idle cycles keeps the frame alive
        idle(2);
        base_to = to_cnt;
        send_byte(8'hA5);
        send_byte(8'h05);
        idle(999);
        send_byte(8'h06);
        send_byte(8'h07);
        send_byte(8'h08);
        send_byte(8'h1A);
        idle(1);
        check_val("no_to_fv", 32'(frame_valid), 32'd1);
        check_val("no_to_sens", sens(), 32'h0506_0708);
        idle(2);
        check_val("no_to_count", 32'(to_cnt - base_to), 32'd0);

        // Reset mid-frame discards partial frame
        send_byte(8'hA5);
        send_byte(8'h11);
        send_byte(8'h22);
        @(negedge clk);
        rx_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        check_val("midrst_sens", sens(), 32'h0000_0000);
        rst_n = 1'b1;
        base_fv = fv_cnt;
        base_ce = ce_cnt;
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'h77);
        idle(3);
        check_val("midrst_no_fv", 32'(fv_cnt - base_fv), 32'd0);
        check_val("midrst_no_ce", 32'(ce_cnt - base_ce), 32'd0);
        check_val("midrst_sens_after", sens(), 32'h0000_0000);

        // Gapped frame
        base_fv = fv_cnt;
        send_byte(8'hA5);
        idle(1);
        send_byte(8'h0A);
        idle(2);
        send_byte(8'h0B);
        idle(3);
        send_byte(8'h0C);
        idle(4);
        send_byte(8'h0D);
        idle(5);
        send_byte(8'h2E);
        idle(1);
        check_val("gap_fv", 32'(frame_valid), 32'd1);
        check_val("gap_sens", sens(), 32'h0A0B_0C0D);
        idle(3);
        check_val("gap_fv_once", 32'(fv_cnt - base_fv), 32'd1);

        check_val("pulses_exclusive", 32'(multi_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sensor_frame_rx.md
SENSOR_FRAME_RX -- requirements
Module: sensor_frame_rx

Interface
REQ-001 The block SHALL have parameter SYNC, default 8'hA5, meaning the frame start byte.
REQ-002 The block SHALL have parameter TIMEOUT, default 16'd1000, meaning the maximum idle clock cycles allowed between bytes inside a frame.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all logic SHALL be rising-edge clk.
REQ-004 The block SHALL have port rst_n, input, 1 bit, an asynchronous active-low reset.
REQ-005 The block SHALL have port rx_data, input, 8 bits, the received byte from the helicopter sensor link.
REQ-006 The block SHALL have port rx_valid, input, 1 bit; rx_data SHALL be accepted on every clk edge where rx_valid=1, with no backpressure.
REQ-007 The block SHALL have ports sensor1, sensor2, sensor3 and sensor4, each an output of 8 bits, holding the last good distance readings, suitable for direct connection to the baggage_drop sensor inputs.
REQ-008 The block SHALL have port frame_valid, output, 1 bit, a one-cycle pulse that marks a sensor update.
REQ-009 The block SHALL have port chk_err, output, 1 bit, a one-cycle pulse on checksum mismatch.
REQ-010 The block SHALL have port timeout_err, output, 1 bit, a one-cycle pulse on an aborted frame.

Function
REQ-011 The frame SHALL be six accepted bytes in this order: SYNC, S1, S2, S3, S4, CHK.
REQ-012 CHK SHALL be correct when it equals (S1+S2+S3+S4) mod 256, computed in 8-bit wrap-around arithmetic.
REQ-013 The state machine SHALL have states HUNT, B1, B2, B3, B4 and CK.
REQ-014 In HUNT, a byte equal to SYNC SHALL move the state to B1, and any other byte SHALL be discarded with the state staying in HUNT.
REQ-015 In B1 through B4, each accepted byte SHALL be stored in a shadow register and SHALL advance the state (B1->B2->B3->B4->CK); the running checksum SHALL be accumulated.
REQ-016 A byte equal to SYNC inside B1 through CK SHALL be treated as data, with no resynchronisation.
REQ-017 In CK, an accepted byte SHALL return the state to HUNT.
REQ-018 On an accepted CK byte that matches, sensor1 through sensor4 SHALL update together from the shadow registers, and frame_valid SHALL be 1 in the cycle after the edge that accepted CK (latency 1 cycle).
REQ-019 On an accepted CK byte that mismatches, chk_err SHALL be 1 in the cycle after acceptance, and sensor outputs SHALL hold their previous values.
REQ-020 Sensor outputs SHALL never show a partial frame; the shadow registers SHALL be invisible at the outputs.
REQ-021 A timeout counter of 16 bits SHALL be cleared on every accepted byte and on entry to HUNT.
REQ-022 The timeout counter SHALL increment on each cycle with rx_valid=0 while the state is not HUNT.
REQ-023 When the timeout counter reaches TIMEOUT, the state SHALL go to HUNT, timeout_err SHALL pulse for one cycle, the counter SHALL clear, and outputs SHALL hold.
REQ-024 If rx_valid=1 in the same cycle the counter would reach TIMEOUT, the byte SHALL win: it is accepted normally and no timeout occurs.
REQ-025 The counter SHALL not increment in HUNT; waiting for SYNC SHALL never time out.
REQ-026 Sensor value 0 SHALL be passed through unchanged; the block SHALL perform no range filtering.
REQ-027 At most one of frame_valid, chk_err and timeout_err SHALL be 1 in any cycle.

Reset
REQ-028 While rst_n=0, asynchronously: state=HUNT, the counter and checksum accumulator SHALL be 0, sensor1 through sensor4 SHALL be 8'h00, and frame_valid, chk_err and timeout_err SHALL be 0.
REQ-029 A reset asserted mid-frame SHALL discard the partial frame, and the first frame after release SHALL need a fresh SYNC.
REQ-030 Operation SHALL resume on the first rising clk edge after rst_n rises.

Verification
REQ-031 Stream A5,10,20,30,40,A0 on consecutive cycles -> one cycle after A0: sensor1..4=10,20,30,40 and frame_valid=1 for exactly one cycle.
REQ-032 Stream A5,FF,FF,01,02,00 (FF+FF+01+02=0x201, mod 256 =0x01), then A5,FF,FF,01,02,01 -> chk_err=1 after the first frame with outputs unchanged, and frame_valid=1 after the second with sensors FF,FF,01,02.
REQ-033 Stream 00,37,A5,01,A5,03,04,AD -> leading 00 and 37 discarded, the inner A5 taken as S2, sensors 01,A5,03,04, and frame_valid pulses.
REQ-034 Stream A5,05 then rx_valid=0 for 1000 cycles -> timeout_err pulses once and the state is HUNT; a subsequent valid frame SHALL be accepted; with rx_valid=0 for 999 cycles then byte 06, no timeout SHALL occur.
REQ-035 Assert rst_n=0 after A5,11,22 mid-frame, then release and stream 33,44,77 -> no frame_valid and sensors remain 00.
REQ-036 Stream A5,0A,0B,0C,0D,2E with idle gaps of 1 to 5 cycles between bytes -> frame_valid pulses once and sensors are 0A,0B,0C,0D.
